// File: rtl/freq_reg_pkg.sv
// Shared types, default widths and the saturating trim-step helper for the
// frequency regulator.
package freq_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        ADJUST  = 2'd2,
        SETTLE  = 2'd3
    } freq_state_t;

    localparam int unsigned DEF_TW         = 8;
    localparam int unsigned DEF_CW         = 16;
    localparam int unsigned DEF_STEP       = 1;
    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam int unsigned DEF_LOCK_CNT   = 3;

    // Saturating add/subtract of a step, clamped to [0, i_max]; widths up to 32.
    function automatic logic [31:0] sat_step(
        input logic [31:0] i_val,
        input logic [31:0] i_step,
        input logic [31:0] i_max,
        input logic        i_up
    );
        logic [32:0] w_sum;
        w_sum = {1'b0, i_val} + {1'b0, i_step};
        if (i_up) begin
            return (w_sum > {1'b0, i_max}) ? i_max : w_sum[31:0];
        end
        return (i_val < i_step) ? 32'd0 : (i_val - i_step);
    endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchroniser followed by a rising-edge detector for an
// asynchronous level; o_rise is a one-cycle pulse in the i_clk domain.
module edge_sync_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise the async input and keep one delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/freq_regulator_param.sv
// Closed-loop ring-oscillator frequency regulator: counts oscillator edges
// over a programmable window, compares against [fmin, fmax] and steps a
// saturating trim word. Optional lock detection with `define FREQ_REG_LOCK_EN.
module freq_regulator_param
    import freq_reg_pkg::*;
#(
    parameter int unsigned   TW         = DEF_TW,
    parameter int unsigned   CW         = DEF_CW,
    parameter int unsigned   STEP       = DEF_STEP,
    parameter logic [TW-1:0] TRIM_INIT  = TW'(8'h80),
    parameter int unsigned   SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned   LOCK_CNT   = DEF_LOCK_CNT
) (
    input  logic          clk_frequency,
    input  logic          rst_frequency,
    input  logic          init,
    input  logic          ring_clk,
    input  logic [CW-1:0] setperiod,
    input  logic [CW-1:0] fmin,
    input  logic [CW-1:0] fmax,
    output logic [TW-1:0] adjusteddiv,
    output logic [TW-1:0] final_sett,
    output logic          co,
    output logic [CW-1:0] meas_count,
    output logic          increment,
    output logic          decrement,
    output logic          sat
`ifdef FREQ_REG_LOCK_EN
    ,
    output logic          locked
`endif
);

    localparam int unsigned   SW       = $clog2(SETTLE_CYC + 2);
    localparam logic [TW-1:0] TRIM_MAX = {TW{1'b1}};

    freq_state_t   r_state;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_fmin;
    logic [CW-1:0] r_fmax;
    logic [CW-1:0] r_win;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_meas;
    logic [SW-1:0] r_set;
    logic [TW-1:0] r_trim;
    logic [TW-1:0] r_final;
    logic          r_co;
    logic          r_inc;
    logic          r_dec;

`ifdef FREQ_REG_LOCK_EN
    localparam int unsigned LW = $clog2(LOCK_CNT + 2);
    logic [LW-1:0] r_lock;
    logic          r_locked;
`endif

    logic          w_edge;
    logic [CW-1:0] w_cnt_next;
    logic          w_last;
    logic          w_co_next;
    logic [TW-1:0] w_trim_up;
    logic [TW-1:0] w_trim_dn;

    edge_sync_detect u_ring_sync (
        .i_clk   (clk_frequency),
        .i_rst_n (rst_frequency),
        .i_async (ring_clk),
        .o_rise  (w_edge)
    );

    assign w_cnt_next = (w_edge && (r_cnt != '1)) ? (r_cnt + CW'(1)) : r_cnt;
    assign w_last     = ((r_win + CW'(1)) == r_period);
    assign w_co_next  = ((r_win + CW'(2)) == r_period);
    assign w_trim_up  = TW'(sat_step(32'(r_trim), 32'(STEP), 32'(TRIM_MAX), 1'b1));
    assign w_trim_dn  = TW'(sat_step(32'(r_trim), 32'(STEP), 32'(TRIM_MAX), 1'b0));

    // Regulator FSM: window measurement, band decision, trim update, settle.
    // co is registered one cycle ahead so it is high during the final MEASURE
    // cycle. SETTLE spends SETTLE_CYC wait cycles plus one relatch cycle, which
    // gives a loop period of 1 + setperiod + 1 + SETTLE_CYC.
    always_ff @(posedge clk_frequency or negedge rst_frequency) begin
        if (!rst_frequency) begin
            r_state  <= IDLE;
            r_period <= '0;
            r_fmin   <= '0;
            r_fmax   <= '0;
            r_win    <= '0;
            r_cnt    <= '0;
            r_meas   <= '0;
            r_set    <= '0;
            r_trim   <= TRIM_INIT;
            r_final  <= TRIM_INIT;
            r_co     <= 1'b0;
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
`ifdef FREQ_REG_LOCK_EN
            r_lock   <= '0;
            r_locked <= 1'b0;
`endif
        end else begin
            r_co  <= 1'b0;
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            if (!init) begin
                r_state <= IDLE;
                r_win   <= '0;
                r_cnt   <= '0;
                r_set   <= '0;
`ifdef FREQ_REG_LOCK_EN
                r_lock   <= '0;
                r_locked <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_win    <= '0;
                        r_cnt    <= '0;
                        r_set    <= '0;
                        r_period <= setperiod;
                        r_fmin   <= fmin;
                        r_fmax   <= fmax;
                        if (setperiod != '0) begin
                            r_state <= MEASURE;
                            r_co    <= (setperiod == CW'(1));
                        end
                    end
                    MEASURE: begin
                        if (w_last) begin
                            r_meas  <= w_cnt_next;
                            r_win   <= '0;
                            r_cnt   <= '0;
                            r_state <= ADJUST;
                        end else begin
                            r_win <= r_win + CW'(1);
                            r_cnt <= w_cnt_next;
                            r_co  <= w_co_next;
                        end
                    end
                    ADJUST: begin
                        if (r_meas < r_fmin) begin
                            r_trim <= w_trim_up;
                            r_inc  <= (w_trim_up != r_trim);
`ifdef FREQ_REG_LOCK_EN
                            r_lock   <= '0;
                            r_locked <= 1'b0;
`endif
                        end else if (r_meas > r_fmax) begin
                            r_trim <= w_trim_dn;
                            r_dec  <= (w_trim_dn != r_trim);
`ifdef FREQ_REG_LOCK_EN
                            r_lock   <= '0;
                            r_locked <= 1'b0;
`endif
                        end else begin
                            r_final <= r_trim;
`ifdef FREQ_REG_LOCK_EN
                            if (r_lock != LW'(LOCK_CNT)) begin
                                r_lock <= r_lock + LW'(1);
                            end
                            r_locked <= (r_lock >= LW'(LOCK_CNT - 1));
`endif
                        end
                        r_set   <= '0;
                        r_state <= SETTLE;
                    end
                    SETTLE: begin
                        if (r_set == SW'(SETTLE_CYC)) begin
                            r_set    <= '0;
                            r_period <= setperiod;
                            r_fmin   <= fmin;
                            r_fmax   <= fmax;
                            if (setperiod != '0) begin
                                r_state <= MEASURE;
                                r_co    <= (setperiod == CW'(1));
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_set <= r_set + SW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign adjusteddiv = r_trim;
    assign final_sett  = r_final;
    assign co          = r_co;
    assign meas_count  = r_meas;
    assign increment   = r_inc;
    assign decrement   = r_dec;
    assign sat         = (r_trim == '0) || (r_trim == TRIM_MAX);
`ifdef FREQ_REG_LOCK_EN
    assign locked      = r_locked;
`endif

endmodule

// File: tb/tb_freq_regulator_param.sv
// Self-checking bench for freq_regulator_param: directed vector table,
// randomized windows against an arithmetic edge-count model, and hand-written
// sequences for loop period, abort, zero period, saturation, lock and reset.
module tb_freq_regulator_param;

    localparam int TRIM0   = 128;
    localparam int SETTLE  = 4;
    localparam int STEP_V  = 1;
    localparam int TRIMMAX = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        init_s = 1'b0;
    logic        ring_clk = 1'b0;
    logic [15:0] setperiod = '0;
    logic [15:0] fmin = '0;
    logic [15:0] fmax = '0;

    logic [7:0]  adjusteddiv, final_sett, adjusteddiv_s, final_sett_s;
    logic [15:0] meas_count, meas_count_s;
    logic        co, increment, decrement, sat;
    logic        co_s, increment_s, decrement_s, sat_s;
`ifdef FREQ_REG_LOCK_EN
    logic        locked, locked_s;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_trim = TRIM0;
    int m_final = TRIM0;
    int ring_div = 10;
    int ph = 0;

    typedef struct {
        int d;
        int p;
        int fmn;
        int fmx;
        int lo;
        int hi;
        int dir;
    } vec_t;

    vec_t vecs[10];

    freq_regulator_param dut (
        .clk_frequency (clk),
        .rst_frequency (rst_n),
        .init          (init),
        .ring_clk      (ring_clk),
        .setperiod     (setperiod),
        .fmin          (fmin),
        .fmax          (fmax),
        .adjusteddiv   (adjusteddiv),
        .final_sett    (final_sett),
        .co            (co),
        .meas_count    (meas_count),
        .increment     (increment),
        .decrement     (decrement),
        .sat           (sat)
`ifdef FREQ_REG_LOCK_EN
        ,
        .locked        (locked)
`endif
    );

    freq_regulator_param #(.TRIM_INIT(8'hFF)) dut_s (
        .clk_frequency (clk),
        .rst_frequency (rst_n),
        .init          (init_s),
        .ring_clk      (ring_clk),
        .setperiod     (setperiod),
        .fmin          (fmin),
        .fmax          (fmax),
        .adjusteddiv   (adjusteddiv_s),
        .final_sett    (final_sett_s),
        .co            (co_s),
        .meas_count    (meas_count_s),
        .increment     (increment_s),
        .decrement     (decrement_s),
        .sat           (sat_s)
`ifdef FREQ_REG_LOCK_EN
        ,
        .locked        (locked_s)
`endif
    );

    always #5 clk = ~clk;

    // Oscillator model: one rising edge every ring_div reference cycles,
    // changing well away from the sampling edge.
    always @(posedge clk) begin
        #3;
        if (ph >= ring_div - 1) ph = 0;
        else ph = ph + 1;
        ring_clk = (ph < ring_div / 2);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [63:0] act, input int lo, input int hi);
        n_cmp++;
        if (act < 64'(lo) || act > 64'(hi)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_co(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (co === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // Band decision over every count the window can produce: +1 raise,
    // -1 lower, 0 hold, 2 when the outcome depends on oscillator phase.
    function automatic int classify(input int lo, input int hi, input int fmn, input int fmx);
        if (hi < fmn) return 1;
        if (lo < fmn) return 2;
        if (lo > fmx) return -1;
        if (hi > fmx) return 2;
        return 0;
    endfunction

    function automatic int clamp_trim(input int v);
        if (v < 0) return 0;
        if (v > TRIMMAX) return TRIMMAX;
        return v;
    endfunction

    task automatic run_window(input string tag, input int d, input int p, input int fmn,
                              input int fmx, input int lo, input int hi, input int dir);
        int n;
        int old_t;
        int new_t;
        ring_div  = d;
        setperiod = 16'(p);
        fmin      = 16'(fmn);
        fmax      = 16'(fmx);
        repeat (24) tick();
        old_t = m_trim;
        new_t = clamp_trim(old_t + dir * STEP_V);
        init = 1'b1;
        wait_co(p + 8, n);
        check({tag, "_co_latency"}, 64'(n), 64'(p));
        tick();
        check({tag, "_co_pulse"}, co, 0);
        check_range({tag, "_meas"}, meas_count, lo, hi);
        check({tag, "_trim_hold"}, adjusteddiv, old_t);
        tick();
        if (dir == 0) m_final = old_t;
        m_trim = new_t;
        check({tag, "_trim"}, adjusteddiv, new_t);
        check({tag, "_inc"}, increment, (new_t > old_t) ? 1 : 0);
        check({tag, "_dec"}, decrement, (new_t < old_t) ? 1 : 0);
        check({tag, "_final"}, final_sett, m_final);
        check({tag, "_sat"}, sat, (new_t == 0 || new_t == TRIMMAX) ? 1 : 0);
        tick();
        check({tag, "_pulse_end"}, {increment, decrement}, 0);
        init = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int n_co;
        int n_inc;
        int n_dec;

        vecs[0] = '{10, 100, 20, 30, 10, 10,  1};  // slow oscillator
        vecs[1] = '{ 3, 100, 20, 30, 33, 34, -1};  // fast oscillator
        vecs[2] = '{ 4, 100, 24, 26, 25, 25,  0};  // in band
        vecs[3] = '{ 4, 100, 40, 10, 25, 25,  1};  // fmin > fmax
        vecs[4] = '{ 5, 100, 20, 30, 20, 20,  0};  // count == fmin
        vecs[5] = '{ 5, 100, 10, 20, 20, 20,  0};  // count == fmax
        vecs[6] = '{ 5, 105, 10, 20, 21, 21, -1};  // fmax + 1
        vecs[7] = '{ 5,  95, 20, 30, 19, 19,  1};  // fmin - 1
        vecs[8] = '{ 4,   1,  0,  5,  0,  1,  0};  // one-cycle window
        vecs[9] = '{ 6,  60, 10, 10, 10, 10,  0};  // fmin == fmax == count

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_trim", adjusteddiv, TRIM0);
        check("rst_final", final_sett, TRIM0);
        check("rst_meas", meas_count, 0);
        check("rst_pulses", {co, increment, decrement}, 0);
        check("rst_sat", sat, 0);
        check("rst_sat_inst", sat_s, 1);
        check("rst_trim_inst", adjusteddiv_s, 8'hFF);
        n_co = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (co === 1'b1) n_co++;
        end
        check("idle_no_co", n_co, 0);
        check("idle_trim", adjusteddiv, TRIM0);

        // Saturation at all-ones: slow oscillator asks for more trim
        ring_div = 10; setperiod = 16'd100; fmin = 16'd20; fmax = 16'd30;
        repeat (24) tick();
        init_s = 1'b1;
        n_co = 0; n_inc = 0; n_dec = 0;
        for (int k = 0; k < 104; k++) begin
            tick();
            if (co_s === 1'b1) n_co++;
            if (increment_s === 1'b1) n_inc++;
            if (decrement_s === 1'b1) n_dec++;
        end
        init_s = 1'b0;
        tick();
        check("sat_co_count", n_co, 1);
        check("sat_no_inc", n_inc, 0);
        check("sat_no_dec", n_dec, 0);
        check("sat_trim", adjusteddiv_s, 8'hFF);
        check("sat_flag", sat_s, 1);
        check("sat_meas", meas_count_s, 10);
        check("sat_final", final_sett_s, 8'hFF);
`ifdef FREQ_REG_LOCK_EN
        check("sat_locked", locked_s, 0);
`endif

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_window($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].fmn,
                       vecs[i].fmx, vecs[i].lo, vecs[i].hi, vecs[i].dir);
        end

        // Randomized windows against the edge-count model
        for (int it = 0; it < 30; it++) begin
            int d;
            int p;
            int lo;
            int hi;
            int fmn;
            int fmx;
            int dir;
            d = int'($urandom_range(3, 12));
            p = int'($urandom_range(2, 150));
            lo = p / d;
            hi = (p + d - 1) / d;
            dir = 2;
            fmn = 0;
            fmx = 0;
            for (int t = 0; t < 100 && dir == 2; t++) begin
                fmn = int'($urandom_range(0, hi + 8));
                fmx = int'($urandom_range(0, hi + 8));
                dir = classify(lo, hi, fmn, fmx);
            end
            if (dir == 2) begin
                fmn = 0;
                fmx = 65535;
                dir = 0;
            end
            run_window($sformatf("rnd%0d", it), d, p, fmn, fmx, lo, hi, dir);
        end

        // Free-running loop period between consecutive co pulses
        ring_div = 7; setperiod = 16'd50; fmin = 16'd0; fmax = 16'hFFFF;
        repeat (24) tick();
        init = 1'b1;
        wait_co(60, n);
        check("loop_first_co", n, 50);
        wait_co(80, n);
        check("loop_period", n, 1 + 50 + 1 + SETTLE);
        m_final = m_trim;
        init = 1'b0;
        tick();
        check("loop_final", final_sett, m_final);
        check("loop_trim", adjusteddiv, m_trim);

        // Abort mid-window: no co, trim unchanged
        ring_div = 10; setperiod = 16'd100; fmin = 16'd20; fmax = 16'd30;
        repeat (24) tick();
        init = 1'b1;
        repeat (40) tick();
        init = 1'b0;
        n_co = 0; n_inc = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (co === 1'b1) n_co++;
            if (increment === 1'b1) n_inc++;
        end
        check("abort_no_co", n_co, 0);
        check("abort_no_inc", n_inc, 0);
        check("abort_trim", adjusteddiv, m_trim);

        // Zero window length stays idle
        setperiod = 16'd0;
        init = 1'b1;
        n_co = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (co === 1'b1) n_co++;
        end
        init = 1'b0;
        tick();
        check("zero_period_no_co", n_co, 0);
        check("zero_period_trim", adjusteddiv, m_trim);

`ifdef FREQ_REG_LOCK_EN
        // Lock after three in-band windows, lost on an out-of-band one
        ring_div = 4; setperiod = 16'd100; fmin = 16'd24; fmax = 16'd26;
        repeat (24) tick();
        init = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            wait_co(120, n);
            check($sformatf("lock_w%0d_co", w), (n > 0) ? 1 : 0, 1);
            tick();
            tick();
            m_final = m_trim;
            check($sformatf("lock_w%0d_locked", w), locked, (w == 3) ? 1 : 0);
            check($sformatf("lock_w%0d_final", w), final_sett, m_final);
        end
        ring_div = 10;
        wait_co(120, n);
        check("unlock_co", (n > 0) ? 1 : 0, 1);
        tick();
        tick();
        m_trim = clamp_trim(m_trim + STEP_V);
        check("unlock_locked", locked, 0);
        check("unlock_inc", increment, 1);
        check("unlock_trim", adjusteddiv, m_trim);
        init = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-window
        ring_div = 5; setperiod = 16'd100; fmin = 16'd0; fmax = 16'd0;
        repeat (24) tick();
        init = 1'b1;
        repeat (30) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_trim", adjusteddiv, TRIM0);
        check("async_rst_final", final_sett, TRIM0);
        check("async_rst_meas", meas_count, 0);
        check("async_rst_co", co, 0);
        init = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_regulator_param.md
# freq_regulator_param

Parametrised closed-loop frequency regulator, next generation of the ring-oscillator tuning loop. It runs on the system reference clock and samples an asynchronous ring-oscillator output. Each measurement window it counts oscillator edges, compares the count with a programmable band, and steps a saturating trim word that drives the oscillator's divider/trim input. It adds configurable widths, step size, a settle delay, saturation flags and optional lock detection, none of which the first-generation regulator had.

## Interface
Parameters:
- `TW`, 8: trim/divider word width.
- `CW`, 16: edge-counter, band and window width.
- `STEP`, 1: trim change per adjustment.
- `TRIM_INIT`, 8'h80: trim value after reset, `TW` bits.
- `SETTLE_CYC`, 4: reference cycles waited after each adjustment before the next window.
- `LOCK_CNT`, 3: consecutive in-band windows needed for lock.

Ports:
- `clk_frequency` in 1: reference clock; all logic on its rising edge.
- `rst_frequency` in 1: reset, asynchronous, active-low.
- `init` in 1: level enable. High runs the loop; low returns to IDLE.
- `ring_clk` in 1: asynchronous oscillator output.
- `setperiod` in CW: measurement window length in reference cycles.
- `fmin` in CW: lower bound of the in-band edge count.
- `fmax` in CW: upper bound of the in-band edge count.
- `adjusteddiv` out TW: current trim word.
- `final_sett` out TW: trim captured at the most recent in-band window.
- `co` out 1: one-cycle pulse at the end of every window.
- `meas_count` out CW: edge count of the last completed window.
- `increment` out 1: one-cycle pulse when trim rises.
- `decrement` out 1: one-cycle pulse when trim falls.
- `sat` out 1: trim is pinned at 0 or at all-ones.
- `locked` out 1: present only with the macro; see Configuration.

## Operation
- **Synchroniser.** `ring_clk` passes through a 2-flop synchroniser, then a rising-edge detector. Valid only while f_ring < f_clk/2.
- **States:** IDLE, MEASURE, ADJUST, SETTLE.
- **IDLE.**
  - Counters clear.
  - With `init`=1, go to MEASURE. On entry, latch `setperiod`, `fmin` and `fmax`.
  - If the latched `setperiod` is 0, stay in IDLE.
- **MEASURE.**
  - The window counter runs for `setperiod` cycles.
  - The edge counter increments on each detected edge and saturates at 2^CW−1.
  - In the final cycle:
    - `co`=1.
    - The count is written to `meas_count`, including an edge detected in that same cycle.
    - Go to ADJUST.
- **ADJUST** (one cycle):
  - Count < `fmin`: trim = min(trim+STEP, 2^TW−1). Pulse `increment` only if the trim value changed.
  - Else count > `fmax`: trim = max(trim−STEP, 0). Pulse `decrement` only if the trim value changed.
  - Else (in-band): `final_sett` ← trim. Neither pulse fires.
  - If `fmin` > `fmax`, the `fmin` test has priority, so the loop always increments.
  - Then go to SETTLE.
- **SETTLE.** Wait `SETTLE_CYC` cycles (0 means skip), then relatch the inputs and go to MEASURE.
- **`init` falling.** From any state, `init`=0 goes to IDLE on the next cycle. `adjusteddiv`, `final_sett` and `meas_count` hold their values. A window in progress is discarded and `co` does not fire.
- **`sat`** is combinational from the trim register.

## Timing
- Reset values:
  - `adjusteddiv`=TRIM_INIT and `final_sett`=TRIM_INIT.
  - `meas_count`=0.
  - `co`, `increment`, `decrement` and `locked` are 0.
  - `sat` reflects TRIM_INIT.
  - State is IDLE.
- Reset assertion mid-window takes effect immediately (asynchronous). Release is synchronised externally.
- Edge-to-count latency: 3 reference cycles (2 synchroniser flops plus the edge register).
- `init`↑ to first MEASURE cycle: 1 cycle.
- `co` fires in the last MEASURE cycle. The trim updates on the following edge, at the ADJUST exit.
- Loop period: 1 + setperiod + 1 + SETTLE_CYC cycles per adjustment.
- Input changes during a window are ignored until the next latch.

## Configuration
- `FREQ_REG_LOCK_EN` defined:
  - A lock counter counts consecutive in-band ADJUST decisions, saturating at `LOCK_CNT`.
  - `locked`=1 once the count reaches `LOCK_CNT`.
  - Any out-of-band window, `init`=0, or reset clears the counter and `locked`.
- `FREQ_REG_LOCK_EN` undefined: the `locked` port and the lock counter are absent. All other behaviour is identical.

## Structure
- Package `freq_reg_pkg` holds:
  - the state enum `freq_state_t` (IDLE, MEASURE, ADJUST, SETTLE);
  - the default width constants;
  - the saturation helper function for trim ±STEP.
- Sub-module `edge_sync_detect`: 2-flop synchroniser plus rising-edge pulse, reset to 0. It is reused for any other asynchronous monitor.

## Test plan
- **Reset.** Reset released, `init`=0. Expect `adjusteddiv`=8'h80, no `co` for 100 cycles.
- **Slow oscillator.** `ring_clk` = clk/10, `setperiod`=100, `fmin`=20, `fmax`=30. Expect `meas_count`=10 ±1, then an `increment` pulse with trim 8'h80→8'h81 one cycle after `co`.
- **Fast oscillator.** `ring_clk` = clk/3, same band. Expect `meas_count`=33 ±1, then `decrement` with trim 8'h80→8'h7F.
- **Saturation.** `TRIM_INIT`=8'hFF, slow oscillator. Expect trim held at 8'hFF, `sat`=1, no `increment` pulse.
- **Lock (macro on).** `ring_clk` = clk/4, `setperiod`=100, band 24..26. Expect `locked`=1 after 3 windows and `final_sett`=8'h80. Then force a window count of 10; expect `locked`=0 and `increment` in that ADJUST.
- **Abort.** Drop `init` mid-window. Expect no `co`, IDLE next cycle, and `adjusteddiv` unchanged.
